// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Contents: access-size encodings, FSM state encoding, latched request
// control fields, and the alignment/size fault check.
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_ILL  = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Control fields captured from the granted requester.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sgn;
    } ctl_t;

    // True for the illegal size code or an address not aligned to the size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == SZ_ILL) begin
            bad = 1'b1;
        end else if (size == SZ_HALF) begin
            bad = addr_lo[0];
        end else if (size == SZ_WORD) begin
            bad = (addr_lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_ext.sv
// dmem_load_ext: zero/sign extension of right-justified load data.
// Ports:
//   raw       in  32  memory read data, zero-filled above the access size
//   size      in   2  access size (byte / half / word)
//   is_signed in   1  replicate the top bit of the accessed field
//   ext       out 32  extended load value
module dmem_load_ext
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            SZ_BYTE: ext = {{24{is_signed & raw[7]}}, raw[7:0]};
            SZ_HALF: ext = {{16{is_signed & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: two-port round-robin sequencer for a byte-addressed
// data memory. Port 0 is the CPU load/store stage, port 1 the debug/DMA
// loader. Each transaction is IDLE (grant) -> ACCESS (one memory cycle)
// -> DONE (one-cycle ack); faulted requests skip ACCESS.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mN_req/we/size/signed    request handshake and control, N = 0, 1
//   mN_addr/wdata            request byte address and store data
//   mN_ack/rdata/err         one-cycle completion with load data and fault
//   mem_ena/w/r/select       memory strobes and size, high only in ACCESS
//   mem_addr/wdata           memory address and write data
//   mem_rdata                memory combinational read data
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic              m0_signed,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic              m1_signed,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic              mem_ena,
    output logic              mem_w,
    output logic              mem_r,
    output logic [1:0]        mem_select,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              last_grant_q;
    logic              gnt_q;
    ctl_t              ctl_q;

    logic              any_req;
    logic              sel_port;
    ctl_t              sel_ctl;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              fault;
    logic [DATA_W-1:0] ext_data;

    logic              mem_ena_d, mem_w_d, mem_r_d;
    logic [1:0]        mem_select_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [1:0]        ack_d;
    logic              err_d;
    logic [DATA_W-1:0] rdata_d;

    // Round-robin selection: on a tie the port that was not granted last wins.
    always_comb begin
        any_req   = m0_req | m1_req;
        sel_port  = 1'b0;
        if (m0_req && m1_req) begin
            sel_port = ~last_grant_q;
        end else if (m1_req) begin
            sel_port = 1'b1;
        end
        sel_ctl   = '0;
        if (sel_port) begin
            sel_ctl.we   = m1_we;
            sel_ctl.size = m1_size;
            sel_ctl.sgn  = m1_signed;
            sel_addr     = m1_addr;
            sel_wdata    = m1_wdata;
        end else begin
            sel_ctl.we   = m0_we;
            sel_ctl.size = m0_size;
            sel_ctl.sgn  = m0_signed;
            sel_addr     = m0_addr;
            sel_wdata    = m0_wdata;
        end
        fault = is_misaligned(sel_ctl.size, sel_addr[1:0]);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = fault ? DONE : ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping; later changes on the request inputs are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            ctl_q        <= '0;
        end else if (state_q == IDLE && any_req) begin
            last_grant_q <= sel_port;
            gnt_q        <= sel_port;
            ctl_q        <= sel_ctl;
        end
    end

    dmem_load_ext u_load_ext (
        .raw       (mem_rdata),
        .size      (ctl_q.size),
        .is_signed (ctl_q.sgn),
        .ext       (ext_data)
    );

    // Output logic: values the output registers take at the next edge, so
    // the memory strobes are high exactly while the FSM sits in ACCESS.
    always_comb begin
        mem_ena_d    = 1'b0;
        mem_w_d      = 1'b0;
        mem_r_d      = 1'b0;
        mem_select_d = 2'b00;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        ack_d        = 2'b00;
        err_d        = 1'b0;
        rdata_d      = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (fault) begin
                        ack_d[sel_port] = 1'b1;
                        err_d           = 1'b1;
                    end else begin
                        mem_ena_d    = 1'b1;
                        mem_w_d      = sel_ctl.we;
                        mem_r_d      = ~sel_ctl.we;
                        mem_select_d = sel_ctl.size;
                        mem_addr_d   = sel_addr;
                        mem_wdata_d  = sel_wdata;
                    end
                end
            end
            ACCESS: begin
                ack_d[gnt_q] = 1'b1;
                rdata_d      = ctl_q.we ? '0 : ext_data;
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ena    <= 1'b0;
            mem_w      <= 1'b0;
            mem_r      <= 1'b0;
            mem_select <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            mem_ena    <= mem_ena_d;
            mem_w      <= mem_w_d;
            mem_r      <= mem_r_d;
            mem_select <= mem_select_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            m0_ack     <= ack_d[0];
            m0_err     <= ack_d[0] & err_d;
            m0_rdata   <= ack_d[0] ? rdata_d : '0;
            m1_ack     <= ack_d[1];
            m1_err     <= ack_d[1] & err_d;
            m1_rdata   <= ack_d[1] ? rdata_d : '0;
        end
    end

endmodule
